// File: rtl/imm_gen_pkg.sv
// Shared opcode and format-code constants for the RV32I immediate generator.
package imm_gen_pkg;

    // Major opcodes (instruction[6:0]) that carry an immediate field
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Register-register ops have no immediate; listed for readability only
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Decoded immediate format codes presented on fmt
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational RV32I immediate extraction: picks the format from the
// opcode and reassembles the scattered immediate bits, sign-extending from bit 31.
module imm_decode
    import imm_gen_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [31:0] imm,
    output logic [2:0]  fmt
);

    logic [6:0] opcode;
    logic       sign;

    assign opcode = instruction[6:0];
    assign sign   = instruction[31];

    // Select the immediate layout by opcode; unknown opcodes yield zero / NONE
    always_comb begin
        imm = 32'd0;
        fmt = FMT_NONE;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                imm = {{20{sign}}, instruction[31:20]};
                fmt = FMT_I;
            end
            OPC_STORE: begin
                imm = {{20{sign}}, instruction[31:25], instruction[11:7]};
                fmt = FMT_S;
            end
            OPC_BRANCH: begin
                imm = {{19{sign}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
                fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm = {instruction[31:12], 12'd0};
                fmt = FMT_U;
            end
            OPC_JAL: begin
                imm = {{11{sign}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
                fmt = FMT_J;
            end
            default: begin
                imm = 32'd0;
                fmt = FMT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/immediate_generator.sv
// One-stage registered immediate generator: decodes each accepted instruction
// and presents imm/fmt one cycle later, holding them while no instruction arrives.
module immediate_generator
    import imm_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        in_valid,
    output logic [31:0] imm,
    output logic [2:0]  fmt,
    output logic        out_valid
);

    logic [31:0] dec_imm;
    logic [2:0]  dec_fmt;

    logic [31:0] imm_d, imm_q;
    logic [2:0]  fmt_d, fmt_q;
    logic        out_valid_d, out_valid_q;

    imm_decode u_decode (
        .instruction (instruction),
        .imm         (dec_imm),
        .fmt         (dec_fmt)
    );

    // Load a new result only for accepted instructions, otherwise keep the last one
    always_comb begin
        imm_d       = imm_q;
        fmt_d       = fmt_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            imm_d = dec_imm;
            fmt_d = dec_fmt;
        end
    end

    // Output register; reset clears any in-flight result immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_q       <= 32'd0;
            fmt_q       <= FMT_NONE;
            out_valid_q <= 1'b0;
        end else begin
            imm_q       <= imm_d;
            fmt_q       <= fmt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imm       = imm_q;
    assign fmt       = fmt_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_immediate_generator.sv
// Directed bench for immediate_generator: expected results are queued when an
// instruction is driven and compared when the registered output appears.
module tb_immediate_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        in_valid = 1'b0;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        out_valid;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] held_imm = 32'd0;
    logic [2:0]  held_fmt = 3'd0;

    immediate_generator dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .in_valid    (in_valid),
        .imm         (imm),
        .fmt         (fmt),
        .out_valid   (out_valid)
    );

    // Free-running 10-time-unit clock
    always #5 clk = ~clk;

    // Guard against a stuck run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Compare registered outputs against the scoreboard (or held values when idle)
    task automatic checkOutput(input string tag, input logic expect_valid);
        exp_t e;
        checkValue({tag, "/out_valid"}, {31'd0, out_valid}, {31'd0, expect_valid});
        if (expect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s/scoreboard: observed empty queue expected an entry", tag);
            end else begin
                e = exp_q.pop_front();
                held_imm = e.imm;
                held_fmt = e.fmt;
            end
        end
        checkValue({tag, "/imm"}, imm, held_imm);
        checkValue({tag, "/fmt"}, {29'd0, fmt}, {29'd0, held_fmt});
    endtask

    // Drive one cycle of stimulus at the falling edge and check after the next rising edge
    task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic valid,
                                 input logic [31:0] e_imm, input logic [2:0] e_fmt);
        @(negedge clk);
        instruction = instr;
        in_valid    = valid;
        if (valid) exp_q.push_back(exp_t'{imm: e_imm, fmt: e_fmt});
        @(posedge clk);
        #1;
        checkOutput(tag, valid);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        checkValue("reset/imm", imm, 32'd0);
        checkValue("reset/fmt", {29'd0, fmt}, 32'd0);
        checkValue("reset/out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back directed vectors
        applyStimulus("rtype",   32'hD2B75DB3, 1'b1, 32'h00000000, 3'd0);
        applyStimulus("addi",    32'h01500013, 1'b1, 32'h00000015, 3'd1);
        applyStimulus("load",    32'h81500003, 1'b1, 32'hFFFFF815, 3'd1);
        applyStimulus("jalr",    32'h01500067, 1'b1, 32'h00000015, 3'd1);
        applyStimulus("system",  32'hB1500073, 1'b1, 32'hFFFFFB15, 3'd1);
        applyStimulus("store",   32'hFF001023, 1'b1, 32'hFFFFFFE0, 3'd2);
        applyStimulus("branch7", 32'h000000E3, 1'b1, 32'h00000800, 3'd3);
        applyStimulus("lui",     32'h2ED80037, 1'b1, 32'h2ED80000, 3'd4);
        applyStimulus("auipc",   32'hAED80017, 1'b1, 32'hAED80000, 3'd4);
        applyStimulus("jal",     32'hD545506F, 1'b1, 32'hFFF55554, 3'd5);

        // Hold while idle: instruction changes but in_valid is low
        applyStimulus("hold1",   32'h01500013, 1'b0, 32'h0, 3'd0);
        applyStimulus("hold2",   32'hFF001023, 1'b0, 32'h0, 3'd0);

        // Sign bit alone, and non-immediate fields all ones
        applyStimulus("bsign",   32'h80000063, 1'b1, 32'hFFFFF000, 3'd3);
        applyStimulus("jsign",   32'h8000006F, 1'b1, 32'hFFF00000, 3'd5);
        applyStimulus("addirs",  32'h015FFF93, 1'b1, 32'h00000015, 3'd1);
        applyStimulus("luilow",  32'h12345FB7, 1'b1, 32'h12345000, 3'd4);

        // Mid-stream reset: an instruction is in flight when reset hits
        @(negedge clk);
        instruction = 32'hB1500073;
        in_valid    = 1'b1;
        #2 rst = 1'b1;
        #1;
        checkValue("midrst/imm", imm, 32'd0);
        checkValue("midrst/fmt", {29'd0, fmt}, 32'd0);
        checkValue("midrst/out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        held_imm = 32'd0;
        held_fmt = 3'd0;
        @(posedge clk);
        #1;
        checkValue("inrst/imm", imm, 32'd0);
        checkValue("inrst/out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // After release, nothing valid until the next accepted instruction
        applyStimulus("postrst_idle", 32'hD545506F, 1'b0, 32'h0, 3'd0);
        applyStimulus("postrst_jal",  32'hD545506F, 1'b1, 32'hFFF55554, 3'd5);
        applyStimulus("postrst_st",   32'hFF001023, 1'b1, 32'hFFFFFFE0, 3'd2);
        applyStimulus("postrst_hold", 32'h00000000, 1'b0, 32'h0, 3'd0);

        checkValue("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
